truth_table_sweeper: RTL and testbench

- Clocked stimulus/capture stage placed directly upstream of a combinational 3-input logic expression under test (e.g. the POS expression block).
- Sweeps {a,b,c} through all 2^N_INPUTS input combinations and waits a settle interval after each one.
- Samples the DUT output f into a truth-table register and compares each sample against an expected truth table.
- Reports done, pass, error count and first failing index, so an on-board FPGA check runs without a simulator.

---
 rtl/truth_table_sweeper.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - stimulus/capture sweeper for a combinational N-input logic block
//
// Drives abc_o through every input combination, holds each vector for
// SETTLE_CYCLES clocks, samples f_i into a captured truth table and compares
// it against a truth table latched at start.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_i             synchronous active-high reset
//   start_i           one-cycle pulse; begins a sweep from IDLE or DONE
//   expected_i        expected truth table (bit i = f for abc==i), latched on start
//   f_i               output of the logic under test
//   abc_o             input vector to the logic under test (MSB = a)
//   tt_o              captured truth table
//   busy_o            sweep in progress
//   done_o            sweep finished, results stable
//   pass_o            no mismatches (valid with done_o)
//   err_count_o       number of mismatching vectors
//   first_err_idx_o   vector index of the first mismatch
//   first_err_valid_o at least one mismatch recorded
module truth_table_sweeper #(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [(1<<N_INPUTS)-1:0]   expected_i,
    input  logic                       f_i,
    output logic [N_INPUTS-1:0]        abc_o,
    output logic [(1<<N_INPUTS)-1:0]   tt_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [N_INPUTS:0]          err_count_o,
    output logic [N_INPUTS-1:0]        first_err_idx_o,
    output logic                       first_err_valid_o
);

    localparam int V     = 1 << N_INPUTS;
    // Counter wide enough to hold SETTLE_CYCLES itself, so SETTLE_CYCLES=1 still gets one bit.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] VEC_LAST = N_INPUTS'(V - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] abc_q, abc_d;
    logic [V-1:0]        tt_q, tt_d;
    logic [V-1:0]        expected_q, expected_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_INPUTS:0]   err_q, err_d;
    logic [N_INPUTS-1:0] fei_q, fei_d;
    logic                fev_q, fev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        abc_d      = abc_q;
        tt_d       = tt_q;
        expected_d = expected_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fei_d      = fei_q;
        fev_d      = fev_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    expected_d = expected_i;
                    abc_d      = '0;
                    tt_d       = '0;
                    err_d      = '0;
                    fev_d      = 1'b0;
                    fei_d      = '0;
                    pass_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[abc_q] = f_i;
                if (f_i != expected_q[abc_q]) begin
                    err_d = err_q + 1'b1;
                    if (!fev_q) begin
                        fei_d = abc_q;
                        fev_d = 1'b1;
                    end
                end
                if (abc_q == VEC_LAST) begin
                    // Uses the updated count so a mismatch on the last vector fails the sweep.
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    abc_d   = abc_q + 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            abc_q      <= '0;
            tt_q       <= '0;
            expected_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fei_q      <= '0;
            fev_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            abc_q      <= abc_d;
            tt_q       <= tt_d;
            expected_q <= expected_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fei_q      <= fei_d;
            fev_q      <= fev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign abc_o             = abc_q;
    assign tt_o              = tt_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_q;
    assign first_err_idx_o   = fei_q;
    assign first_err_valid_o = fev_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (SETTLE_CYCLES=4)
    logic       rst, start, f;
    logic [7:0] expected;
    logic [2:0] abc;
    logic [7:0] tt;
    logic       busy, done, pass, fev;
    logic [3:0] errc;
    logic [2:0] fei;

    // Second instance (SETTLE_CYCLES=1)
    logic       rst2, start2, f2;
    logic [7:0] expected2;
    logic [2:0] abc2;
    logic [7:0] tt2;
    logic       busy2, done2, pass2, fev2;
    logic [3:0] errc2;
    logic [2:0] fei2;

    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .expected_i(expected), .f_i(f),
        .abc_o(abc), .tt_o(tt), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(errc), .first_err_idx_o(fei), .first_err_valid_o(fev)
    );

    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dut2 (
        .clk_i(clk), .rst_i(rst2), .start_i(start2), .expected_i(expected2), .f_i(f2),
        .abc_o(abc2), .tt_o(tt2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .err_count_o(errc2), .first_err_idx_o(fei2), .first_err_valid_o(fev2)
    );

    // Logic under test: mode 0 = a|(b&c), otherwise lookup in fn_tbl.
    int         mode;
    logic [7:0] fn_tbl;
    always_comb begin
        if (mode == 0) f = abc[2] | (abc[1] & abc[0]);
        else           f = fn_tbl[abc];
        f2 = abc2[2] | (abc2[1] & abc2[0]);
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: build the truth table from a function rule, then score it.
    function automatic logic [7:0] ref_tt(input int m, input logic [7:0] tbl);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (m == 0) r[i] = ((i >> 2) & 1) | (((i >> 1) & 1) & (i & 1));
            else        r[i] = tbl[i];
        end
        return r;
    endfunction

    typedef struct {
        int         m;
        logic [7:0] tbl;
        logic [7:0] exp_in;
        int         ign_at;   // cycle after start to pulse start while busy, -1 = none
    } vec_t;

    // Run one sweep on the main DUT and compare everything to the model.
    task automatic run_sweep(input string tag, input vec_t v);
        logic [7:0] rtt, diff;
        int cyc, rerr, rfirst;
        bit overlap;
        mode = v.m; fn_tbl = v.tbl; expected = v.exp_in;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        expected = ~v.exp_in;      // must not affect the sweep in progress
        cyc = 0; overlap = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == v.ign_at);
            if (done && busy) overlap = 1;
            if (!done && !busy) overlap = 1;
        end
        start = 1'b0;
        rtt = ref_tt(v.m, v.tbl);
        diff = rtt ^ v.exp_in;
        rerr = $countones(diff);
        rfirst = 0;
        for (int i = 7; i >= 0; i--) if (diff[i]) rfirst = i;
        chk({tag, " latency"}, cyc, 40);
        chk({tag, " busy/done exclusive"}, int'(overlap), 0);
        chk({tag, " tt"}, int'(tt), int'(rtt));
        chk({tag, " err_count"}, int'(errc), rerr);
        chk({tag, " pass"}, int'(pass), int'(rerr == 0));
        chk({tag, " first_err_valid"}, int'(fev), int'(rerr != 0));
        if (rerr != 0) chk({tag, " first_err_idx"}, int'(fei), rfirst);
        chk({tag, " abc holds last"}, int'(abc), 7);
        // DONE is stable while start stays low
        repeat (5) @(posedge clk);
        #1;
        chk({tag, " done held"}, int'(done), 1);
        chk({tag, " tt held"}, int'(tt), int'(rtt));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int cyc;
        rst = 1'b1; start = 1'b0; expected = '0; mode = 0; fn_tbl = '0;
        rst2 = 1'b1; start2 = 1'b0; expected2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;

        chk("reset abc", int'(abc), 0);
        chk("reset tt", int'(tt), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pass", int'(pass), 0);
        chk("reset err_count", int'(errc), 0);
        chk("reset first_err_valid", int'(fev), 0);
        chk("reset first_err_idx", int'(fei), 0);

        vecs.push_back('{0, 8'h00, 8'hF8, -1});   // clean pass
        vecs.push_back('{0, 8'h00, 8'hFA, -1});   // bit 1 wrong
        vecs.push_back('{1, 8'h00, 8'hFF, -1});   // f tied low
        vecs.push_back('{0, 8'h00, 8'h78, -1});   // mismatch only on last vector
        vecs.push_back('{0, 8'h00, 8'hF8, 12});   // start while busy ignored
        vecs.push_back('{0, 8'h00, 8'hF8, -1});   // restart from DONE clears results
        for (int i = 0; i < vecs.size(); i++) run_sweep($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v.m = 1;
            v.tbl = 8'($urandom);
            v.exp_in = (i % 3 == 0) ? v.tbl : 8'($urandom);
            v.ign_at = int'($urandom_range(0, 45));
            run_sweep($sformatf("rnd%0d", i), v);
        end

        // Reset mid-sweep abandons it without raising done.
        mode = 0; expected = 8'hF8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst abc", int'(abc), 0);
        chk("midrst tt", int'(tt), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst err_count", int'(errc), 0);
        cyc = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done || busy) cyc++;
        end
        chk("midrst stays idle", cyc, 0);
        v = '{0, 8'h00, 8'hF8, -1};
        run_sweep("after_rst", v);

        // SETTLE_CYCLES=1 instance: 2 clocks per vector, done 16 clocks after start.
        expected2 = 8'hF8; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("s1 latency", cyc, 16);
        chk("s1 tt", int'(tt2), int'(ref_tt(0, 8'h00)));
        chk("s1 pass", int'(pass2), 1);
        chk("s1 err_count", int'(errc2), 0);
        chk("s1 first_err_valid", int'(fev2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
